pc_unit_ras: RTL

//  Next-generation program-counter unit: parametrised PC register, next-PC select and condition-gated write.

---
 rtl/pc_unit_pkg.sv | 8 +
 rtl/pc_unit_ras_stack.sv | 43 ++++
 rtl/pc_unit_ras.sv | 67 ++++++
 3 files changed

// File: rtl/pc_unit_pkg.sv
// pc_unit_pkg: next-PC source encodings shared by the PC unit and its bench
package pc_unit_pkg;
  localparam logic [2:0] PCSRC_INC = 3'd0;
  localparam logic [2:0] PCSRC_JMP = 3'd1;
  localparam logic [2:0] PCSRC_REG = 3'd2;
  localparam logic [2:0] PCSRC_REL = 3'd3;
  localparam logic [2:0] PCSRC_RET = 3'd4;
endpackage

// File: rtl/pc_unit_ras_stack.sv
// ras_stack: circular return-address stack, oldest entry overwritten on overflow, sticky err
module ras_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         top,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     err
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] ptr;
  logic [AW-1:0] up;
  assign up = ptr + 1'b1;
  assign top = mem[ptr];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
      count <= '0;
      err <= 1'b0;
    end else if (push && pop && !empty) begin
      mem[ptr] <= data_in;
    end else if (push) begin
      ptr <= up;
      mem[up] <= data_in;
      count <= full ? count : count + 1'b1;
      err <= err | full | pop;
    end else if (pop) begin
      ptr <= empty ? ptr : ptr - 1'b1;
      count <= empty ? count : count - 1'b1;
      err <= err | empty;
    end
  end
endmodule

// File: rtl/pc_unit_ras.sv
// pc_unit_ras: PC register with next-PC select, branch gating, stall and optional RAS (PC_UNIT_RAS_EN)
module pc_unit_ras
  import pc_unit_pkg::*;
#(
  parameter int              PC_W      = 16,
  parameter int              JUMP_W    = 12,
  parameter int              OFF_W     = 8,
  parameter int              RAS_DEPTH = 4,
  parameter logic [PC_W-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            pc_write,
  input  logic            beq_cond,
  input  logic            bne_cond,
  input  logic            zero,
  input  logic [2:0]      pc_source,
  input  logic            call,
  input  logic [PC_W-1:0] ir,
  input  logic [PC_W-1:0] a_data,
  output logic [PC_W-1:0] pc,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_err
);
  logic            take;
  logic [PC_W-1:0] inc;
  logic [PC_W-1:0] rel;
  logic [PC_W-1:0] ret;
  logic [PC_W-1:0] next_pc;
  assign take = ~stall & (pc_write | (beq_cond & zero) | (bne_cond & ~zero));
  assign inc = pc + 1'b1;
  assign rel = inc + {{(PC_W-OFF_W){ir[OFF_W-1]}}, ir[OFF_W-1:0]};
`ifdef PC_UNIT_RAS_EN
  logic [PC_W-1:0]             ras_top;
  logic [$clog2(RAS_DEPTH):0]  ras_count;
  ras_stack #(.WIDTH(PC_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clk(clk),
    .reset(reset),
    .push(take & call),
    .pop(take & (pc_source == PCSRC_RET)),
    .data_in(inc),
    .top(ras_top),
    .count(ras_count),
    .full(ras_full),
    .empty(ras_empty),
    .err(ras_err)
  );
  assign ret = ras_empty ? a_data : ras_top;
`else
  assign ret = a_data;
  assign ras_empty = 1'b1;
  assign ras_full = 1'b0;
  assign ras_err = 1'b0;
`endif
  always_comb begin
    next_pc = pc_source == PCSRC_JMP ? {pc[PC_W-1:JUMP_W], ir[JUMP_W-1:0]} :
              pc_source == PCSRC_REG ? a_data :
              pc_source == PCSRC_REL ? rel :
              pc_source == PCSRC_RET ? ret : inc;
  end
  always_ff @(posedge clk) begin
    if (reset) pc <= RESET_PC;
    else if (take) pc <= next_pc;
  end
endmodule
